core_pcctrl: RTL
================

Name: core_pcctrl

Overview:
- Program-counter and fetch-redirect stage sitting directly downstream of the branch-condition unit.
- Consumes the registered TAKE_BRANCH decision, which is valid one cycle after C_BRANCH.
- Computes branch and jump targets and drives the fetch PC/valid handshake toward instruction memory.
- Flushes younger pipeline stages on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles FLUSH is held after a redirect. Legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- NRST  input  1  reset, asynchronous, active-low.
- C_BRANCH  input  1  a conditional branch is in EX this cycle; BR_PC and BR_IMM are valid.
- BR_PC  input  32  PC of the branch instruction.
- BR_IMM  input  32  sign-extended B-type immediate.
- TAKE_BRANCH  input  1  registered branch decision, valid the cycle after C_BRANCH.
- C_JUMP  input  1  JAL/JALR in EX; JUMP_TARGET is valid.
- JUMP_TARGET  input  32  computed jump target (rs1+imm or PC+imm).
- STALL  input  1  downstream hazard stall; gates fetch only.
- IF_READY  input  1  instruction memory accepts the request this cycle.
- IF_VALID  output  1  fetch request valid.
- PC  output  32  fetch address.
- FLUSH  output  1  kill younger in-flight instructions.
- MISALIGNED  output  1  one-cycle pulse: redirect target not 4-byte aligned.

Behaviour:
- States: IDLE, RUN, WAIT_BR, FLUSHING. The state and all registers reset asynchronously when NRST is low.
- Reset values: state=IDLE, PC=RESET_PC, FLUSH=0, MISALIGNED=0, flush counter=0. IF_VALID is 0 whenever NRST is low.
- IF_VALID is combinational: IF_VALID = (state==RUN) & ~STALL.
- IDLE: moves to RUN on the first rising edge with NRST high. No other action.
- RUN, with priority C_JUMP > C_BRANCH > sequential:
  - C_JUMP: tgt = JUMP_TARGET & ~32'h1.
    - If tgt[1]=1: MISALIGNED=1 for one cycle, PC holds, stay in RUN.
    - Else: PC<=tgt, FLUSH<=1, counter<=FLUSH_CYCLES, go to FLUSHING.
  - C_BRANCH: latch br_tgt = BR_PC + BR_IMM (32-bit, wraps modulo 2^32), go to WAIT_BR. PC holds; the same-cycle fetch handshake is ignored and PC is not advanced.
  - Otherwise, if IF_VALID & IF_READY: PC <= PC + 4, wrapping 32'hFFFF_FFFC -> 32'h0. If IF_VALID & ~IF_READY, PC holds; the request stays asserted and unchanged until accepted.
- WAIT_BR: IF_VALID=0. Samples TAKE_BRANCH on the next edge.
  - TAKE_BRANCH=0: go to RUN, PC unchanged (fall-through).
  - TAKE_BRANCH=1 and br_tgt[1:0]!=0: MISALIGNED pulse, PC unchanged, go to RUN.
  - TAKE_BRANCH=1 and aligned: PC<=br_tgt, FLUSH<=1, counter<=FLUSH_CYCLES, go to FLUSHING.
- FLUSHING: FLUSH=1, IF_VALID=0. The counter decrements each cycle. The state returns to RUN on the edge where the counter reaches 1, and FLUSH deasserts on that same edge. FLUSH is therefore high for exactly FLUSH_CYCLES cycles.
- C_BRANCH and C_JUMP are honoured only in RUN. They are ignored in IDLE, WAIT_BR and FLUSHING, with no state or PC change.
- STALL affects IF_VALID only. Redirects in RUN are taken regardless of STALL.
- MISALIGNED is registered and high for exactly one cycle per offending redirect. It never coincides with FLUSH from the same redirect.
- Reset asserted mid-WAIT_BR or mid-FLUSHING: the block immediately enters IDLE, the latched br_tgt is discarded, and all outputs return to their reset values.

Test Plan:
- Reset release, IF_READY=1, STALL=0 -> IF_VALID rises one cycle after NRST high; PC runs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- PC=0x100, C_BRANCH with BR_PC=0x100 and BR_IMM=-16, TAKE_BRANCH=1 next cycle -> PC=0xF0; FLUSH high exactly 2 cycles; IF_VALID=0 during WAIT_BR/FLUSHING; fetch resumes at 0xF0.
- Same stimulus with TAKE_BRANCH=0 -> no FLUSH; PC stays 0x100; IF_VALID=0 for one cycle, then fetch resumes at 0x100.
- C_JUMP with JUMP_TARGET=0x2001 -> PC=0x2000, FLUSH 2 cycles. C_JUMP with 0x2002 -> MISALIGNED one cycle, PC unchanged, no FLUSH.
- C_JUMP and C_BRANCH in the same cycle -> jump wins, no WAIT_BR. C_JUMP pulsed during FLUSHING -> ignored.
- PC=0xFFFF_FFFC with a fetch accepted -> PC=0x0. IF_READY=0 for 3 cycles -> PC and IF_VALID held. NRST asserted in WAIT_BR -> PC=RESET_PC immediately, FLUSH=0.

Source files
------------

// File: rtl/core_pcctrl.sv
// Fetch program counter and redirect control. Handles the sequential fetch handshake,
// jump and branch redirects, younger-stage flush timing and misaligned-target reporting.
module core_pcctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        C_BRANCH,
    input  logic [31:0] BR_PC,
    input  logic [31:0] BR_IMM,
    input  logic        TAKE_BRANCH,
    input  logic        C_JUMP,
    input  logic [31:0] JUMP_TARGET,
    input  logic        STALL,
    input  logic        IF_READY,
    output logic        IF_VALID,
    output logic [31:0] PC,
    output logic        FLUSH,
    output logic        MISALIGNED
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_BR, FLUSHING} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_br_tgt, w_br_tgt_nx;
    logic        r_flush, w_flush_nx;
    logic        r_mis, w_mis_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_br_sum;
    logic        w_fetch;

    assign w_jmp_tgt  = JUMP_TARGET & ~32'h1;
    assign w_br_sum   = BR_PC + BR_IMM;
    assign IF_VALID   = (r_state == RUN) & ~STALL;
    assign w_fetch    = IF_VALID & IF_READY;
    assign PC         = r_pc;
    assign FLUSH      = r_flush;
    assign MISALIGNED = r_mis;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_br_tgt <= 32'h0;
            r_flush  <= 1'b0;
            r_mis    <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_br_tgt <= w_br_tgt_nx;
            r_flush  <= w_flush_nx;
            r_mis    <= w_mis_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_br_tgt_nx = r_br_tgt;
        w_flush_nx  = r_flush;
        w_mis_nx    = 1'b0;
        w_cnt_nx    = r_cnt;
        unique case (r_state)
            IDLE: w_state_nx = RUN;
            RUN: begin
                // Redirects win over the fetch handshake presented in the same cycle.
                if (C_JUMP) begin
                    if (w_jmp_tgt[1]) begin
                        w_mis_nx = 1'b1;
                    end else begin
                        w_pc_nx    = w_jmp_tgt;
                        w_flush_nx = 1'b1;
                        w_cnt_nx   = FLUSH_LOAD;
                        w_state_nx = FLUSHING;
                    end
                end else if (C_BRANCH) begin
                    w_br_tgt_nx = w_br_sum;
                    w_state_nx  = WAIT_BR;
                end else if (w_fetch) begin
                    w_pc_nx = r_pc + 32'd4;
                end
            end
            WAIT_BR: begin
                w_state_nx = RUN;
                if (TAKE_BRANCH) begin
                    if (r_br_tgt[1:0] != 2'b00) begin
                        w_mis_nx = 1'b1;
                    end else begin
                        w_pc_nx    = r_br_tgt;
                        w_flush_nx = 1'b1;
                        w_cnt_nx   = FLUSH_LOAD;
                        w_state_nx = FLUSHING;
                    end
                end
            end
            FLUSHING: begin
                // Leaving on the count==1 edge keeps FLUSH high for exactly the loaded count.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nx   = 4'd0;
                    w_flush_nx = 1'b0;
                    w_state_nx = RUN;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

endmodule
